// File: rtl/keypad_word_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// keypad_word_ctrl_pkg
// Shared definitions for keypad-timed blocks: special key codes, the word
// controller state encoding and the default sample-tick divider.
// ---------------------------------------------------------------------------
package keypad_word_ctrl_pkg;

  // Default keypad sample period in clk cycles; display scan reuses it.
  localparam int DEFAULT_TICK_DIV = 60000;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_POUND = 4'hB;
  localparam logic [3:0] DIGIT_MAX = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_DEBOUNCE     = 3'd1,
    S_ACTION       = 3'd2,
    S_WAIT_RELEASE = 3'd3,
    S_SUBMIT       = 3'd4
  } kw_state_e;

endpackage

// File: rtl/keypad_word_ctrl_if.sv
// ---------------------------------------------------------------------------
// keypad_word_ctrl_if
// Bundles the keypad-side inputs and the word-side valid/ready output of the
// keypad word controller.
//   master : the controller (consumes keypad, produces word)
//   slave  : the environment (drives keypad and word_ready)
// Signals:
//   key_valid  raw level, 1 while any key is held
//   key_code   held key code
//   word_valid submitted word available
//   word_ready consumer accepts the word
//   word_len   current length
//   word_data  buffer, char i at [i*KEY_W +: KEY_W]
//   overflow   one-clk pulse when a digit is dropped
//   busy       controller not idle
// ---------------------------------------------------------------------------
interface keypad_word_ctrl_if #(
  parameter int MAX_LEN = 7,
  parameter int KEY_W   = 4
);
  logic                     key_valid;
  logic [KEY_W-1:0]         key_code;
  logic                     word_valid;
  logic                     word_ready;
  logic [2:0]               word_len;
  logic [MAX_LEN*KEY_W-1:0] word_data;
  logic                     overflow;
  logic                     busy;

  modport master (
    input  key_valid, key_code, word_ready,
    output word_valid, word_len, word_data, overflow, busy
  );

  modport slave (
    output key_valid, key_code, word_ready,
    input  word_valid, word_len, word_data, overflow, busy
  );
endinterface

// File: rtl/keypad_word_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// keypad_word_ctrl_tick_gen
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as a
// one-clk tick.
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   o_tick  1 for one clk every TICK_DIV clks
// ---------------------------------------------------------------------------
module keypad_word_ctrl_tick_gen
  import keypad_word_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);
  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler counter, wraps after the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == LAST) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/keypad_word_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_word_ctrl
// Keypad word entry sequencer. Samples the keypad on a prescaled tick,
// debounces over two ticks, acts once per physical press, collects digits
// into a word buffer, clears on star and submits on pound over valid/ready.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    keypad_word_ctrl_if.master (keypad in, word out)
// ---------------------------------------------------------------------------
module keypad_word_ctrl
  import keypad_word_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int MAX_LEN  = 7,
  parameter int KEY_W    = 4
) (
  input logic                clk,
  input logic                reset,
  keypad_word_ctrl_if.master bus
);
  localparam int         DW      = MAX_LEN * KEY_W;
  localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

  localparam logic [2:0] ST_IDLE         = S_IDLE;
  localparam logic [2:0] ST_DEBOUNCE     = S_DEBOUNCE;
  localparam logic [2:0] ST_ACTION       = S_ACTION;
  localparam logic [2:0] ST_WAIT_RELEASE = S_WAIT_RELEASE;
  localparam logic [2:0] ST_SUBMIT       = S_SUBMIT;

  logic             w_tick;
  logic             w_is_digit;
  logic             w_is_star;
  logic             w_is_pound;
  logic [2:0]       w_state_nxt;
  logic [2:0]       r_state;
  logic [KEY_W-1:0] r_key;
  logic [2:0]       r_len;
  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_ovf;
  logic             r_busy;

  keypad_word_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // Classification of the key latched at the start of the press.
  assign w_is_digit = (r_key <= KEY_W'(DIGIT_MAX));
  assign w_is_star  = (r_key == KEY_W'(KEY_STAR));
  assign w_is_pound = (r_key == KEY_W'(KEY_POUND));

  // Next-state logic; ACTION always leaves after one clk so a tick landing
  // on it is simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && bus.key_valid) w_state_nxt = ST_DEBOUNCE;
        else                         w_state_nxt = ST_IDLE;
      end
      ST_DEBOUNCE: begin
        // A released or changed key at the confirming tick aborts the press.
        if (w_tick) begin
          if (bus.key_valid && (bus.key_code == r_key)) w_state_nxt = ST_ACTION;
          else                                          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DEBOUNCE;
        end
      end
      ST_ACTION: begin
        if (w_is_pound && (r_len != 3'd0)) w_state_nxt = ST_SUBMIT;
        else                               w_state_nxt = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (w_tick && !bus.key_valid) w_state_nxt = ST_IDLE;
        else                          w_state_nxt = ST_WAIT_RELEASE;
      end
      ST_SUBMIT: begin
        if (r_valid && bus.word_ready) w_state_nxt = ST_WAIT_RELEASE;
        else                           w_state_nxt = ST_SUBMIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, word buffer and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_key   <= {KEY_W{1'b0}};
      r_len   <= 3'd0;
      r_data  <= {DW{1'b0}};
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ovf   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick && bus.key_valid) r_key <= bus.key_code;
        end
        ST_ACTION: begin
          if (w_is_digit) begin
            if (r_len < LEN_MAX) begin
              r_data[r_len*KEY_W +: KEY_W] <= r_key;
              r_len                        <= r_len + 3'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (w_is_star) begin
            r_len  <= 3'd0;
            r_data <= {DW{1'b0}};
          end else if (w_is_pound && (r_len != 3'd0)) begin
            r_valid <= 1'b1;
          end
        end
        ST_SUBMIT: begin
          // Word, length and valid stay frozen until the consumer takes it.
          if (r_valid && bus.word_ready) begin
            r_valid <= 1'b0;
            r_len   <= 3'd0;
            r_data  <= {DW{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.word_valid = r_valid;
  assign bus.word_len   = r_len;
  assign bus.word_data  = r_data;
  assign bus.overflow   = r_ovf;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_keypad_word_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_word_ctrl
// Self-checking bench for keypad_word_ctrl with TICK_DIV=4. A reference model
// keeps the word as a list of digits; submitted words go to a scoreboard
// queue that a negedge monitor pops on each handshake.
// ---------------------------------------------------------------------------
module tb_keypad_word_ctrl;
  localparam int TICK_DIV = 4;
  localparam int MAX_LEN  = 7;
  localparam int KEY_W    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  keypad_word_ctrl_if #(.MAX_LEN(MAX_LEN), .KEY_W(KEY_W)) bus ();

  keypad_word_ctrl #(
    .TICK_DIV (TICK_DIV),
    .MAX_LEN  (MAX_LEN),
    .KEY_W    (KEY_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  len;
    logic [27:0] data;
  } word_t;

  int    errors  = 0;
  int    checks  = 0;
  int    exp_ovf = 0;
  int    obs_ovf = 0;
  word_t exp_q[$];
  int    model_digits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] model_data();
    logic [27:0] d;
    d = 28'd0;
    for (int i = 0; i < model_digits.size(); i++)
      d = d | (28'(model_digits[i]) << (4 * i));
    return d;
  endfunction

  // Reference behaviour of one accepted press.
  task automatic model_apply(input int code, output bit sub);
    word_t w;
    sub = 1'b0;
    if (code <= 9) begin
      if (model_digits.size() < MAX_LEN) model_digits.push_back(code);
      else exp_ovf++;
    end else if (code == 10) begin
      model_digits.delete();
    end else if (code == 11) begin
      if (model_digits.size() > 0) begin
        w.len  = 3'(model_digits.size());
        w.data = model_data();
        exp_q.push_back(w);
        model_digits.delete();
        sub = 1'b1;
      end
    end
  endtask

  // Monitor: overflow pulse count, word stability, scoreboard pop on handshake.
  initial begin : monitor
    bit    have;
    word_t cur;
    word_t e;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || !bus.word_valid) begin
        have = 1'b0;
      end else begin
        if (!have) begin
          have     = 1'b1;
          cur.len  = bus.word_len;
          cur.data = bus.word_data;
        end else begin
          check("word_stable", {1'b0, bus.word_len, bus.word_data}, {1'b0, cur.len, cur.data});
        end
        if (bus.word_ready) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_len", 32'(bus.word_len), 32'(e.len));
            check("sb_data", 32'(bus.word_data), 32'(e.data));
          end
          have = 1'b0;
        end
      end
      if (reset && bus.overflow) obs_ovf++;
    end
  end

  task automatic key_down(input int code);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    repeat (3 * TICK_DIV + $urandom_range(0, 3)) @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'($urandom_range(0, 15));
  endtask

  task automatic key_gap();
    repeat (2 * TICK_DIV + $urandom_range(0, 3)) @(posedge clk);
    #1;
    check("live_len", 32'(bus.word_len), 32'(model_digits.size()));
    check("live_data", 32'(bus.word_data), 32'(model_data()));
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.word_valid), 32'd0);
  endtask

  task automatic handshake(input int dly);
    int n;
    n = 0;
    while (!bus.word_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_seen", 32'(bus.word_valid), 32'd1);
    repeat (dly) begin
      @(posedge clk); #1;
      check("valid_held", 32'(bus.word_valid), 32'd1);
    end
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    check("hs_valid_clr", 32'(bus.word_valid), 32'd0);
    check("hs_len_clr", 32'(bus.word_len), 32'd0);
    check("hs_data_clr", 32'(bus.word_data), 32'd0);
    check("hs_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic press(input int code, input int dly);
    bit sub;
    key_down(code);
    model_apply(code, sub);
    if (sub) handshake(dly);
    key_gap();
  endtask

  int ovf0;
  int code;

  initial begin : stim
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.word_ready = 1'b0;

    // Power-on reset, then run a few clks so the prescaler is mid-count.
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-count with a key already held: first tick 4 clks after release.
    reset         = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hC;
    repeat (3) @(posedge clk);
    #1;
    check("rst_len", 32'(bus.word_len), 32'd0);
    check("rst_data", 32'(bus.word_data), 32'd0);
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("tick_not_yet", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 check("tick_at_4", 32'(bus.busy), 32'd1);
    repeat (8) @(posedge clk);
    #1 bus.key_valid = 1'b0;
    key_gap();

    // Digits 3,1,4.
    press(3, 0); press(1, 0); press(4, 0);
    check("w413_len", 32'(bus.word_len), 32'd3);
    check("w413_data", 32'(bus.word_data[11:0]), 32'h413);
    check("w413_noovf", 32'(obs_ovf), 32'(exp_ovf));

    // Star clears a 3-digit word.
    press(10, 0);
    check("star_len", 32'(bus.word_len), 32'd0);

    // Eight digits saturate at seven with one overflow pulse.
    ovf0 = obs_ovf;
    for (int d = 1; d <= 8; d++) press(d, 0);
    check("sat_len", 32'(bus.word_len), 32'd7);
    check("sat_slot6", 32'(bus.word_data[27:24]), 32'd7);
    check("sat_data", 32'(bus.word_data), 32'h7654321);
    check("sat_ovf", 32'(obs_ovf - ovf0), 32'd1);
    press(10, 0);

    // Glitch: key seen on one tick only.
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    repeat (TICK_DIV) @(posedge clk);
    #1 bus.key_valid = 1'b0;
    key_gap();

    // 5,2,pound with the consumer stalling for 10 clks.
    press(5, 0); press(2, 0); press(11, 10);

    // Pound on an empty word.
    press(11, 0);

    // Reset while a word is waiting: dropped without handshake.
    press(6, 0);
    key_down(11);
    check("rs_valid_pre", 32'(bus.word_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("rs_valid", 32'(bus.word_valid), 32'd0);
    check("rs_len", 32'(bus.word_len), 32'd0);
    model_digits.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    key_gap();

    // Randomized key sequence.
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      code = $urandom_range(0, 9);
      else if (r < 70) code = 10;
      else if (r < 85) code = 11;
      else             code = $urandom_range(12, 15);
      press(code, $urandom_range(0, 6));
    end

    check("ovf_total", 32'(obs_ovf), 32'(exp_ovf));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
